// File: rtl/rmii_tx_serializer.sv
// RMII transmit serializer: preamble, SFD, payload dibits, optional CRC-32
// FCS and inter-frame gap, with underrun abort.
// Ports:
//   i_clock, i_reset_n          50 MHz reference clock, async active-low reset
//   i_byte/_valid/_last         payload byte stream from the frame buffer
//   o_byte_ready                byte consumed on this edge when valid is high
//   o_TXD, o_TX_EN              registered RMII transmit dibit and enable
//   o_busy                      high whenever not IDLE
//   o_frame_done, o_underrun    one-cycle completion / abort pulses
module rmii_tx_serializer #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int IFG_BYTES      = 12,
   parameter int GEN_FCS        = 1
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic [7:0] i_byte,
   input  logic       i_byte_valid,
   input  logic       i_byte_last,
   output logic       o_byte_ready,
   output logic [1:0] o_TXD,
   output logic       o_TX_EN,
   output logic       o_busy,
   output logic       o_frame_done,
   output logic       o_underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_FCS,
      S_IFG
   } state_t;

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES * 4 - 1);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES * 4 - 1);
   localparam logic [31:0] POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic        last_q, last_d;
   logic [31:0] crc_q, crc_d;
   logic [1:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;
   logic        done_q, done_d;
   logic        underrun_q, underrun_d;
   logic        ready;
   logic [31:0] fcs_w;

   function automatic logic [31:0] crc_next(input logic [31:0] crc,
                                            input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
      return c;
   endfunction

   // State and counters describe the dibit currently on o_TXD; the
   // output flops are loaded from the next state so they stay aligned.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 8'd1;
      byte_d     = byte_q;
      last_d     = last_q;
      crc_d      = crc_q;
      underrun_d = 1'b0;
      ready      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d  = 8'd0;
            last_d = 1'b0;
            crc_d  = CRC_INIT;
            if (i_byte_valid) state_d = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            if (cnt_q == PRE_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_SFD;
            end
         end
         S_SFD, S_DATA: begin
            if (cnt_q == 8'd3) begin
               cnt_d = 8'd0;
               if (state_q == S_DATA && last_q) begin
                  state_d = (GEN_FCS != 0) ? S_FCS : S_IFG;
               end else begin
                  ready = 1'b1;
                  if (i_byte_valid) begin
                     state_d = S_DATA;
                     byte_d  = i_byte;
                     last_d  = i_byte_last;
                     crc_d   = crc_next(crc_q, i_byte);
                  end else begin
                     state_d    = S_IFG;
                     underrun_d = 1'b1;
                  end
               end
            end
         end
         S_FCS: begin
            if (cnt_q == 8'd15) begin
               cnt_d   = 8'd0;
               state_d = S_IFG;
            end
         end
         S_IFG: begin
            // The edge closing the gap doubles as the IDLE start decision,
            // so back-to-back frames see exactly IFG_BYTES*4 quiet clocks.
            if (cnt_q == IFG_LAST) begin
               cnt_d   = 8'd0;
               last_d  = 1'b0;
               crc_d   = CRC_INIT;
               state_d = i_byte_valid ? S_PREAMBLE : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // crc_q is final once the last byte is loaded, so the FCS reads it directly.
   assign fcs_w = ~crc_q;

   always_comb begin
      txd_d   = 2'b00;
      tx_en_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_d)
         S_PREAMBLE: begin
            tx_en_d = 1'b1;
            txd_d   = 2'b01;
         end
         S_SFD: begin
            tx_en_d = 1'b1;
            txd_d   = (cnt_d == 8'd3) ? 2'b11 : 2'b01;
         end
         S_DATA: begin
            tx_en_d = 1'b1;
            txd_d   = byte_d[{cnt_d[1:0], 1'b0} +: 2];
            done_d  = (GEN_FCS == 0) && last_d && (cnt_d == 8'd3);
         end
         S_FCS: begin
            tx_en_d = 1'b1;
            txd_d   = fcs_w[{cnt_d[3:0], 1'b0} +: 2];
            done_d  = (cnt_d == 8'd15);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         byte_q     <= 8'd0;
         last_q     <= 1'b0;
         crc_q      <= CRC_INIT;
         txd_q      <= 2'b00;
         tx_en_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_q     <= byte_d;
         last_q     <= last_d;
         crc_q      <= crc_d;
         txd_q      <= txd_d;
         tx_en_q    <= tx_en_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   assign o_byte_ready = ready;
   assign o_TXD        = txd_q;
   assign o_TX_EN      = tx_en_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_frame_done = done_q;
   assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Bench for rmii_tx_serializer: table of frames plus hand-written
// back-to-back, underrun, no-FCS and mid-frame reset sequences.
module tb_rmii_tx_serializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] b = 8'h00;
   logic       v = 1'b0;
   logic       l = 1'b0;

   logic       rdy1, en1, busy1, done1, und1;
   logic [1:0] txd1;
   logic       rdy0, en0, busy0, done0, und0;
   logic [1:0] txd0;

   always #10 clk = ~clk;

   rmii_tx_serializer dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_byte(b), .i_byte_valid(v), .i_byte_last(l),
      .o_byte_ready(rdy1), .o_TXD(txd1), .o_TX_EN(en1),
      .o_busy(busy1), .o_frame_done(done1), .o_underrun(und1)
   );

   rmii_tx_serializer #(.GEN_FCS(0)) dut0 (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_byte(b), .i_byte_valid(v), .i_byte_last(l),
      .o_byte_ready(rdy0), .o_TXD(txd0), .o_TX_EN(en0),
      .o_busy(busy0), .o_frame_done(done0), .o_underrun(und0)
   );

   bit         sel = 1'b0;
   logic       m_rdy, m_en, m_busy, m_done, m_und;
   logic [1:0] m_txd;
   assign m_rdy  = sel ? rdy0  : rdy1;
   assign m_en   = sel ? en0   : en1;
   assign m_busy = sel ? busy0 : busy1;
   assign m_done = sel ? done0 : done1;
   assign m_und  = sel ? und0  : und1;
   assign m_txd  = sel ? txd0  : txd1;

   int errors = 0;
   int checks = 0;

   logic [1:0] exp_q[$];
   logic [7:0] pl[$];

   int          en_cnt, done_cnt, done_at, und_cnt, rdy_cnt;
   int          ifg_cnt, low_run, last_gap;
   logic        und_en, und_prev, prev_en;
   logic [31:0] cap;
   bit          mon_chk = 1'b1;

   typedef struct {
      int          n;
      logic [71:0] d;
      int          en;
   } vec_t;
   vec_t vec[4];

   function automatic logic [31:0] crc_model(input logic [31:0] c0,
                                             input logic [7:0]  d);
      logic [31:0] c;
      c = c0;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
         else c = c >> 1;
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic mon();
      logic [1:0] e;
      if (m_en) begin
         en_cnt++;
         cap = {m_txd, cap[31:2]};
         if (mon_chk) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL dibit %0d: got %b, none expected",
                        en_cnt, m_txd);
            end else begin
               e = exp_q.pop_front();
               if (m_txd !== e) begin
                  errors++;
                  $display("FAIL dibit %0d: got %b expected %b",
                           en_cnt, m_txd, e);
               end
            end
         end
         if (low_run > 0) last_gap = low_run;
         low_run = 0;
      end else begin
         low_run++;
         if (m_busy) ifg_cnt++;
         checks++;
         if (m_txd !== 2'b00) begin
            errors++;
            $display("FAIL idle_txd: got %b expected 00", m_txd);
         end
      end
      if (m_done) begin
         done_cnt++;
         done_at = en_cnt;
      end
      if (m_und) begin
         und_cnt++;
         und_en   = m_en;
         und_prev = prev_en;
      end
      if (m_rdy) rdy_cnt++;
      prev_en = m_en;
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
   endtask

   task automatic clear_mon();
      en_cnt = 0; done_cnt = 0; done_at = 0; und_cnt = 0; rdy_cnt = 0;
      ifg_cnt = 0; low_run = 0; last_gap = 0; cap = 32'h0;
      und_en = 1'b0; und_prev = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy0 || busy1) && t < 1000) begin
         tick();
         t++;
      end
      if (t >= 1000) begin
         checks++; errors++;
         $display("FAIL idle_timeout: busy still high after %0d clocks", t);
      end
   endtask

   task automatic push_exp(input int drop_at, input bit fcs);
      int          k;
      logic [31:0] c;
      logic [31:0] f;
      logic [7:0]  x;
      for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
      exp_q.push_back(2'b11);
      k = (drop_at < 0) ? pl.size() : drop_at;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < k; i++) begin
         x = pl[i];
         c = crc_model(c, x);
         for (int j = 0; j < 4; j++) exp_q.push_back(x[2*j +: 2]);
      end
      if (drop_at < 0 && fcs) begin
         f = ~c;
         for (int j = 0; j < 16; j++) exp_q.push_back(f[2*j +: 2]);
      end
   endtask

   task automatic send(input int drop_at, input bit keep);
      int n = pl.size();
      int idx = 0;
      int t = 0;
      push_exp(drop_at, !sel);
      while (idx < n && idx != drop_at && t < 4000) begin
         b = pl[idx];
         l = (idx == n - 1);
         v = 1'b1;
         if (m_rdy) idx++;
         tick();
         t++;
      end
      if (t >= 4000) begin
         checks++; errors++;
         $display("FAIL send_timeout: got %0d bytes required %0d", idx, n);
      end
      if (idx == drop_at) v = 1'b0;
      if (!keep) begin
         v = 1'b0;
         l = 1'b0;
         t = 0;
         while (m_busy && t < 2000) begin
            tick();
            t++;
         end
         if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL frame_timeout: busy still high");
         end
      end
   endtask

   initial begin
      int t;
      vec[0] = '{9, 72'h39_38_37_36_35_34_33_32_31, 84};
      vec[1] = '{1, 72'h00, 52};
      vec[2] = '{4, 72'hEF_BE_AD_DE, 64};
      vec[3] = '{3, 72'h55_00_FF, 60};
      clear_mon();
      prev_en = 1'b0;

      // reset state, with valid high to show nothing starts
      v = 1'b1;
      repeat (3) tick();
      chk("rst_en", m_en, 0);
      chk("rst_txd", m_txd, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_rdy", m_rdy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_und", m_und, 0);
      v = 1'b0;
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 4; i++) begin
         wait_idle();
         pl.delete();
         for (int k = 0; k < vec[i].n; k++) pl.push_back(vec[i].d[k*8 +: 8]);
         clear_mon();
         send(-1, 1'b0);
         chk($sformatf("v%0d_en", i), en_cnt, vec[i].en);
         chk($sformatf("v%0d_done", i), done_cnt, 1);
         chk($sformatf("v%0d_done_at", i), done_at, vec[i].en);
         chk($sformatf("v%0d_und", i), und_cnt, 0);
         chk($sformatf("v%0d_rdy", i), rdy_cnt, vec[i].n);
         chk($sformatf("v%0d_left", i), exp_q.size(), 0);
         chk($sformatf("v%0d_ifg", i), ifg_cnt, 48);
         if (i == 0) chk("fcs_bytes", cap, 32'hCBF43926);
      end

      // back-to-back single-byte frames
      wait_idle();
      pl.delete();
      pl.push_back(8'hA5);
      clear_mon();
      send(-1, 1'b1);
      send(-1, 1'b0);
      chk("b2b_gap", last_gap, 48);
      chk("b2b_rdy", rdy_cnt, 2);
      chk("b2b_done", done_cnt, 2);
      chk("b2b_en", en_cnt, 104);
      chk("b2b_left", exp_q.size(), 0);

      // underrun at the byte-4 boundary of a 5-byte frame
      wait_idle();
      pl.delete();
      pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      clear_mon();
      send(3, 1'b0);
      chk("ur_und", und_cnt, 1);
      chk("ur_en_after", und_en, 0);
      chk("ur_en_before", und_prev, 1);
      chk("ur_done", done_cnt, 0);
      chk("ur_en", en_cnt, 44);
      chk("ur_ifg", ifg_cnt, 48);
      chk("ur_rdy", rdy_cnt, 4);
      chk("ur_left", exp_q.size(), 0);

      // no-FCS instance, 2-byte frame
      wait_idle();
      sel = 1'b1;
      pl.delete();
      pl = '{8'h12, 8'h34};
      clear_mon();
      send(-1, 1'b0);
      chk("nf_en", en_cnt, 40);
      chk("nf_done", done_cnt, 1);
      chk("nf_done_at", done_at, 40);
      chk("nf_payload", cap[31:16], 16'h3412);
      chk("nf_ifg", ifg_cnt, 48);
      chk("nf_left", exp_q.size(), 0);
      sel = 1'b0;

      // reset pulse at payload clock 10, restart on first edge after
      wait_idle();
      mon_chk = 1'b0;
      clear_mon();
      b = 8'h55;
      l = 1'b0;
      v = 1'b1;
      t = 0;
      while (en_cnt < 42 && t < 300) begin
         tick();
         t++;
      end
      chk("rs_reach", en_cnt, 42);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_en", m_en, 0);
      chk("rs_txd", m_txd, 0);
      chk("rs_busy", m_busy, 0);
      tick();
      tick();
      clear_mon();
      for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
      exp_q.push_back(2'b11);
      for (int i = 0; i < 8; i++) exp_q.push_back(2'b01);
      mon_chk = 1'b1;
      rst_n = 1'b1;
      repeat (40) tick();
      mon_chk = 1'b0;
      chk("rs_restart_en", en_cnt, 40);
      chk("rs_left", exp_q.size(), 0);
      v = 1'b0;
      wait_idle();
      chk("rs_und", und_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
